// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit ALU: operation encodings and datapath width.
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/alu_addsub8.sv
// 8-bit adder/subtractor: sum = a + (sub ? ~b : b) + sub; purely combinational.
module alu_addsub8
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  logic [DATA_W-1:0] w_b_eff;
  logic [DATA_W:0]   w_sum_ext;

  assign w_b_eff   = sub ? ~b : b;
  assign w_sum_ext = {1'b0, a} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, sub};
  assign sum       = w_sum_ext[DATA_W-1:0];
  assign cout      = w_sum_ext[DATA_W];
  // Same-sign addends producing a different-sign sum; b is taken post-inversion.
  assign ovf       = (a[DATA_W-1] == w_b_eff[DATA_W-1]) &&
                     (w_sum_ext[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/alu_8bit_unit.sv
// Four-op 8-bit ALU with registered result and flags.
// Latency 1 cycle; accepts an op every cycle, no backpressure.
module alu_8bit_unit
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] inputA,
  input  logic [DATA_W-1:0] inputB,
  input  logic [1:0]        operation,
  output logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  output logic              carry_flag,
  output logic              overflow_flag,
  output logic              zero_flag,
  output logic              negative_flag
);

  logic [DATA_W-1:0] w_sum;
  logic              w_cout;
  logic              w_ovf;
  logic [DATA_W-1:0] w_res;
  logic              w_carry;
  logic              w_overflow;

  logic [DATA_W-1:0] r_res;
  logic              r_vld;
  logic              r_carry;
  logic              r_ovf;
  logic              r_zero;
  logic              r_neg;

  alu_addsub8 u_addsub (
    .a    (inputA),
    .b    (inputB),
    .sub  (operation == OP_SUB),
    .sum  (w_sum),
    .cout (w_cout),
    .ovf  (w_ovf)
  );

  always_comb begin
    w_res      = w_sum;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    unique case (operation)
      OP_ADD: begin
        w_carry    = w_cout;
        w_overflow = w_ovf;
      end
      // Borrow is the inverse of the carry-out of A + ~B + 1.
      OP_SUB: begin
        w_carry    = ~w_cout;
        w_overflow = w_ovf;
      end
      OP_AND:  w_res = inputA & inputB;
      OP_OR:   w_res = inputA | inputB;
      default: w_res = w_sum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res   <= '0;
      r_vld   <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_res   <= w_res;
        r_carry <= w_carry;
        r_ovf   <= w_overflow;
        r_zero  <= (w_res == '0);
        r_neg   <= w_res[DATA_W-1];
      end
    end
  end

  assign alu_result    = r_res;
  assign out_valid     = r_vld;
  assign carry_flag    = r_carry;
  assign overflow_flag = r_ovf;
  assign zero_flag     = r_zero;
  assign negative_flag = r_neg;

endmodule

// File: tb/tb_alu_8bit_unit.sv
// Self-checking bench for alu_8bit_unit: integer-arithmetic reference model,
// per-cycle compare on the falling edge, directed literal cases and random traffic.
module tb_alu_8bit_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] inputA;
  logic [7:0] inputB;
  logic [1:0] operation;
  logic [7:0] alu_result;
  logic       out_valid;
  logic       carry_flag;
  logic       overflow_flag;
  logic       zero_flag;
  logic       negative_flag;

  int errors = 0;
  int checks = 0;

  alu_8bit_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .inputA        (inputA),
    .inputB        (inputB),
    .operation     (operation),
    .alu_result    (alu_result),
    .out_valid     (out_valid),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {result[7:0], carry, overflow, zero, negative}.
  function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    int ua, ub, sa, sb, r, sr;
    logic [7:0] res;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        r = ua + ub;   res = r[7:0];
        c = (r > 255);
        sr = sa + sb;  v = (sr > 127) || (sr < -128);
      end
      2'd1: begin
        r = ua - ub;   res = r[7:0];
        c = (ua < ub);
        sr = sa - sb;  v = (sr > 127) || (sr < -128);
      end
      2'd2: res = a & b;
      default: res = a | b;
    endcase
    return {res, c, v, (res == 8'h00), res[7]};
  endfunction

  logic [11:0] exp_out;
  logic        exp_vld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_out <= '0;
      exp_vld <= 1'b0;
    end else begin
      exp_vld <= in_valid;
      if (in_valid) exp_out <= ref_alu(inputA, inputB, operation);
    end
  end

  function automatic logic [12:0] dut_vec();
    return {out_valid, alu_result, carry_flag, overflow_flag, zero_flag, negative_flag};
  endfunction

  always @(negedge clk) begin
    checks++;
    if (dut_vec() !== {exp_vld, exp_out}) begin
      errors++;
      $display("FAIL model_cmp t=%0t got vld/res/c/v/z/n=%h expected %h",
               $time, dut_vec(), {exp_vld, exp_out});
    end
  end

  // Called just after a rising edge: drive one op, then check it after the next edge.
  task automatic op_lit(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [11:0] lit);
    logic [11:0] m;
    in_valid  = 1'b1;
    inputA    = a;
    inputB    = b;
    operation = op;
    m = ref_alu(a, b, op);
    checks++;
    if (m !== lit) begin
      errors++;
      $display("FAIL model_%s model=%h expected %h", name, m, lit);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== {1'b1, lit}) begin
      errors++;
      $display("FAIL %s got vld/res/c/v/z/n=%h expected %h", name, dut_vec(), {1'b1, lit});
    end
  endtask

  task automatic check_vec(input string name, input logic [12:0] want);
    checks++;
    if (dut_vec() !== want) begin
      errors++;
      $display("FAIL %s got vld/res/c/v/z/n=%h expected %h", name, dut_vec(), want);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inputA    = 8'h00;
    inputB    = 8'h00;
    operation = 2'b00;
    #12;
    check_vec("reset_state", 13'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    op_lit("add_cc_aa", 8'hCC, 8'hAA, 2'b00, {8'h76, 4'b1100});
    op_lit("sub_cc_aa", 8'hCC, 8'hAA, 2'b01, {8'h22, 4'b0000});
    op_lit("and_cc_aa", 8'hCC, 8'hAA, 2'b10, {8'h88, 4'b0001});
    op_lit("or_cc_aa",  8'hCC, 8'hAA, 2'b11, {8'hEE, 4'b0001});
    op_lit("add_80_80", 8'h80, 8'h80, 2'b00, {8'h00, 4'b1110});
    op_lit("sub_05_07", 8'h05, 8'h07, 2'b01, {8'hFE, 4'b1001});
    op_lit("add_7f_01", 8'h7F, 8'h01, 2'b00, {8'h80, 4'b0101});
    op_lit("sub_80_01", 8'h80, 8'h01, 2'b01, {8'h7F, 4'b0100});
    op_lit("and_0f_f0", 8'h0F, 8'hF0, 2'b10, {8'h00, 4'b0010});
    op_lit("or_a5_5a",  8'hA5, 8'h5A, 2'b11, {8'hFF, 4'b0001});

    // Idle: valid drops, result and flags hold; inputs wiggle without effect.
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inputA    = 8'($urandom);
      inputB    = 8'($urandom);
      operation = 2'($urandom);
      @(posedge clk);
      #1;
      check_vec("hold_idle", {1'b0, 8'hFF, 4'b0001});
    end

    // Mid-cycle async reset after an op has been published, with another op pending.
    op_lit("pre_reset", 8'h12, 8'h34, 2'b00, {8'h46, 4'b0000});
    inputA    = 8'hF0;
    inputB    = 8'h0F;
    operation = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("async_reset", 13'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_vec("post_reset_idle", 13'h0);
    end

    // Random traffic, checked every cycle by the model compare.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      inputA    = 8'($urandom);
      inputB    = 8'($urandom);
      operation = 2'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
